// File: rtl/rollcall_scan.sv
// Roll-call matcher: loads N_SLOTS slot codes, then checks each circular adjacent
// pair (S[i], S[(i+1)%N]) against a pattern, one pair per clock.
module rollcall_scan #(
    parameter int N_SLOTS = 4,
    parameter int W       = 2,
    parameter int IDX_W   = $clog2(N_SLOTS),
    parameter int CNT_W   = $clog2(N_SLOTS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_data,
    input  logic               clear,
    input  logic               start,
    input  logic [W-1:0]       pat,
    input  logic               mode,
    output logic               busy,
    output logic               done,
    output logic [N_SLOTS-1:0] match,
    output logic               any,
    output logic               par,
    output logic [CNT_W-1:0]   count,
    output logic [IDX_W-1:0]   first
);

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_FULL = 2'd1;
    localparam logic [1:0] ST_SCAN = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SLOTS - 1);

    logic [1:0]         state;
    logic [IDX_W-1:0]   wr_ptr;
    logic [IDX_W-1:0]   idx;
    logic [W-1:0]       slots [N_SLOTS];
    logic [W-1:0]       pat_q;
    logic               mode_q;
    logic               start_q;
    logic [N_SLOTS-1:0] match_r;
    logic [CNT_W-1:0]   count_r;
    logic [IDX_W-1:0]   first_r;

    logic [IDX_W-1:0]   nxt_idx;
    logic [W-1:0]       want_b;
    logic               hit;

    // Pair compare for the current scan index; pair N-1 wraps back to slot 0.
    always_comb begin
        nxt_idx = (idx == LAST_IDX) ? {IDX_W{1'b0}} : idx + IDX_W'(1);
        want_b  = mode_q ? ~pat_q : pat_q;
        hit     = (slots[idx] == pat_q) && (slots[nxt_idx] == want_b);
    end

    // start is captured into start_q on the sampling edge; the FSM leaves FULL one edge later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_LOAD;
            wr_ptr  <= {IDX_W{1'b0}};
            idx     <= {IDX_W{1'b0}};
            pat_q   <= {W{1'b0}};
            mode_q  <= 1'b0;
            start_q <= 1'b0;
            match_r <= {N_SLOTS{1'b0}};
            count_r <= {CNT_W{1'b0}};
            first_r <= {IDX_W{1'b0}};
            for (int i = 0; i < N_SLOTS; i++) slots[i] <= {W{1'b0}};
        end else if (clear) begin
            state   <= ST_LOAD;
            wr_ptr  <= {IDX_W{1'b0}};
            idx     <= {IDX_W{1'b0}};
            start_q <= 1'b0;
            match_r <= {N_SLOTS{1'b0}};
            count_r <= {CNT_W{1'b0}};
            first_r <= {IDX_W{1'b0}};
        end else begin
            case (state)
                ST_LOAD: begin
                    start_q <= 1'b0;
                    if (in_valid) begin
                        slots[wr_ptr] <= in_data;
                        if (wr_ptr == LAST_IDX) begin
                            wr_ptr <= {IDX_W{1'b0}};
                            state  <= ST_FULL;
                        end else begin
                            wr_ptr <= wr_ptr + IDX_W'(1);
                        end
                    end
                end
                ST_FULL: begin
                    start_q <= start & ~start_q;
                    if (start && !start_q) begin
                        pat_q   <= pat;
                        mode_q  <= mode;
                        match_r <= {N_SLOTS{1'b0}};
                        count_r <= {CNT_W{1'b0}};
                        first_r <= {IDX_W{1'b0}};
                    end
                    if (start_q) begin
                        state <= ST_SCAN;
                        idx   <= {IDX_W{1'b0}};
                    end
                end
                ST_SCAN: begin
                    start_q <= 1'b0;
                    if (hit) begin
                        match_r[idx] <= 1'b1;
                        count_r      <= count_r + CNT_W'(1);
                        if (match_r == {N_SLOTS{1'b0}}) first_r <= idx;
                    end
                    idx <= nxt_idx;
                    if (idx == LAST_IDX) state <= ST_DONE;
                end
                ST_DONE: begin
                    start_q <= 1'b0;
                    state   <= ST_FULL;
                end
                default: begin
                    start_q <= 1'b0;
                    state   <= ST_LOAD;
                end
            endcase
        end
    end

    assign in_ready = (state == ST_LOAD);
    assign busy     = (state == ST_SCAN);
    assign done     = (state == ST_DONE);
    assign match    = match_r;
    assign any      = |match_r;
    assign par      = ^match_r;
    assign count    = count_r;
    assign first    = first_r;

endmodule
